// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input handshake plus instruction-memory
// write port and status lines of the boot program loader.
// master = stream source / memory / core side, slave = the loader itself.
interface prog_loader_if #(
  parameter int IW  = 8,
  parameter int IMW = 4
) ();
  logic           in_valid;
  logic [7:0]     in_data;
  logic           in_ready;
  logic           imem_we;
  logic [IMW-1:0] imem_addr;
  logic [IW-1:0]  imem_wdata;
  logic           start;
  logic           busy;
  logic           err;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, start, busy, err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, start, busy, err
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: boot-time loader. Receives <N> <N*IW/8 data bytes, LSB first>
// [<checksum>] over a valid/ready byte stream, writes each assembled word to
// instruction memory and releases the core with start once the image is in.
// A bad length (or bad checksum) locks the loader in ERR until reset.
// Optional feature macro: GLORB_LOADER_CHECKSUM_EN enables the trailing
// checksum byte (sum mod 256 of data bytes) and the CSUM state.
module prog_loader #(
  parameter int IW  = 8,
  parameter int IMW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  prog_loader_if.slave  bus_io
);

  localparam int             NB        = IW / 8;
  localparam int             BCW       = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BCW-1:0] LAST_LANE = BCW'(NB - 1);
  localparam logic [BCW-1:0] BC_ONE    = BCW'(1);
  localparam logic [8:0]     DEPTH     = 9'(1 << IMW);
  localparam logic [IMW:0]   WC_ONE    = {{IMW{1'b0}}, 1'b1};

`ifdef GLORB_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_DATA = 3'd1,
    ST_CSUM = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_DATA = 3'd1,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_e;
`endif

  state_e         state_q, state_d;
  logic           armed_q;
  logic [IMW:0]   n_q, n_d;
  logic [IMW:0]   wcnt_q, wcnt_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [IW-1:0]  asm_q, asm_d;
  logic           we_q, we_d;
  logic [IMW-1:0] addr_q, addr_d;
  logic [IW-1:0]  wdata_q, wdata_d;
  logic           start_q, err_q, busy_q;
`ifdef GLORB_LOADER_CHECKSUM_EN
  logic [7:0]     acc_q, acc_d;
`endif

  logic           in_ready_s;
  logic           accept_s;
  logic [8:0]     len9_s;
  logic [IMW:0]   wcnt_inc_s;
  logic [IW-1:0]  asm_ins_s;

  assign accept_s   = bus_io.in_valid & in_ready_s;
  assign len9_s     = {1'b0, bus_io.in_data};
  assign wcnt_inc_s = wcnt_q + WC_ONE;

  assign bus_io.in_ready   = in_ready_s;
  assign bus_io.imem_we    = we_q;
  assign bus_io.imem_addr  = addr_q;
  assign bus_io.imem_wdata = wdata_q;
  assign bus_io.start      = start_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.err        = err_q;

  // Ready depends on state only; held low until the first edge after reset.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      ST_HDR:  in_ready_s = armed_q;
      ST_DATA: in_ready_s = armed_q;
`ifdef GLORB_LOADER_CHECKSUM_EN
      ST_CSUM: in_ready_s = armed_q;
`endif
      default: in_ready_s = 1'b0;
    endcase
  end

  // Drop the incoming byte into lane bcnt of the word being assembled.
  always_comb begin
    asm_ins_s = asm_q;
    for (int l = 0; l < NB; l++) begin
      if (bcnt_q == BCW'(l)) begin
        asm_ins_s[l*8 +: 8] = bus_io.in_data;
      end else begin
        asm_ins_s[l*8 +: 8] = asm_q[l*8 +: 8];
      end
    end
  end

  // Next-state logic: header check, word assembly/writes, checksum compare.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef GLORB_LOADER_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      ST_HDR: begin
        if (accept_s) begin
          if ((len9_s == 9'd0) || (len9_s > DEPTH)) begin
            state_d = ST_ERR;
          end else begin
            n_d     = len9_s[IMW:0];
            wcnt_d  = '0;
            bcnt_d  = '0;
            asm_d   = '0;
`ifdef GLORB_LOADER_CHECKSUM_EN
            acc_d   = 8'h00;
`endif
            state_d = ST_DATA;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
`ifdef GLORB_LOADER_CHECKSUM_EN
          acc_d = acc_q + bus_io.in_data;
`endif
          if (bcnt_q == LAST_LANE) begin
            we_d    = 1'b1;
            addr_d  = wcnt_q[IMW-1:0];
            wdata_d = asm_ins_s;
            wcnt_d  = wcnt_inc_s;
            bcnt_d  = '0;
            asm_d   = '0;
            if (wcnt_inc_s == n_q) begin
`ifdef GLORB_LOADER_CHECKSUM_EN
              state_d = ST_CSUM;
`else
              state_d = ST_RUN;
`endif
            end else begin
              state_d = state_q;
            end
          end else begin
            bcnt_d = bcnt_q + BC_ONE;
            asm_d  = asm_ins_s;
          end
        end else begin
          state_d = state_q;
        end
      end
`ifdef GLORB_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept_s) begin
          if (bus_io.in_data == acc_q) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_ERR;
          end
        end else begin
          state_d = state_q;
        end
      end
`endif
      ST_RUN:  state_d = ST_RUN;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HDR;
      armed_q <= 1'b0;
      n_q     <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef GLORB_LOADER_CHECKSUM_EN
      acc_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      start_q <= (state_d == ST_RUN);
      err_q   <= (state_d == ST_ERR);
`ifdef GLORB_LOADER_CHECKSUM_EN
      busy_q  <= (state_d == ST_DATA) || (state_d == ST_CSUM);
      acc_q   <= acc_d;
`else
      busy_q  <= (state_d == ST_DATA);
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven bench for prog_loader (IW=8, IMW=4) plus a
// second IW=16 instance for the wrap/width case. Follows the build's
// GLORB_LOADER_CHECKSUM_EN setting for stream contents and expectations.
module tb_prog_loader;

  logic clk;
  logic rst_n;

  prog_loader_if #(.IW(8),  .IMW(4)) bus8  ();
  prog_loader_if #(.IW(16), .IMW(4)) bus16 ();

  prog_loader #(.IW(8),  .IMW(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus_io(bus8.slave));
  prog_loader #(.IW(16), .IMW(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus_io(bus16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]       nb;
    logic [19:0][7:0] b;
    logic [4:0]       nw;
    logic [15:0][7:0] w;
    logic             exp_start;
    logic             exp_err;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  int checks   = 0;
  int failures = 0;

  // write monitors (captured on the falling edge)
  logic [3:0]  wr_addr  [128];
  logic [7:0]  wr_data  [128];
  logic        wr_start [128];
  int          wr_cnt = 0;
  logic [3:0]  w16_addr;
  logic [15:0] w16_data;
  int          w16_cnt = 0;

  always @(negedge clk) begin
    if (bus8.imem_we === 1'b1) begin
      wr_addr[wr_cnt % 128]  = bus8.imem_addr;
      wr_data[wr_cnt % 128]  = bus8.imem_wdata;
      wr_start[wr_cnt % 128] = bus8.start;
      wr_cnt++;
    end
    if (bus16.imem_we === 1'b1) begin
      w16_addr = bus16.imem_addr;
      w16_data = bus16.imem_wdata;
      w16_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_in(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin
      bus16.in_valid = v;
      bus16.in_data  = d;
    end else begin
      bus8.in_valid = v;
      bus8.in_data  = d;
    end
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? bus16.in_ready : bus8.in_ready;
  endfunction

  // drive one byte (optionally after idle gaps) and return after its accept edge
  task automatic send_byte(input bit sel, input logic [7:0] b, input bit gaps);
    int   gap;
    logic rdy;
    if (gaps) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin
        @(negedge clk);
        set_in(sel, 1'b0, ~b);
      end
    end
    @(negedge clk);
    set_in(sel, 1'b1, b);
    rdy = get_ready(sel);
    for (int k = 0; k < 8 && rdy !== 1'b1; k++) begin
      @(negedge clk);
      rdy = get_ready(sel);
    end
    check("in_ready_wait", {31'd0, rdy}, 32'd1);
    @(posedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 8'h00);
    set_in(1'b1, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input bit gaps, input bit do_rst);
    int base;
    if (do_rst) apply_reset();
    base = wr_cnt;
    for (int i = 0; i < int'(v.nb); i++) send_byte(1'b0, v.b[i], gaps);
    @(negedge clk);
    set_in(1'b0, 1'b0, 8'h00);
    check("start_after_last", {31'd0, bus8.start}, {31'd0, v.exp_start});
    check("err_after_last",   {31'd0, bus8.err},   {31'd0, v.exp_err});
    @(negedge clk);
    check("write_count", wr_cnt - base, {27'd0, v.nw});
    for (int i = 0; i < int'(v.nw); i++) begin
      check("write_addr", {28'd0, wr_addr[(base + i) % 128]}, i);
      check("write_data", {24'd0, wr_data[(base + i) % 128]}, {24'd0, v.w[i]});
    end
    if (v.nw != 5'd0) begin
`ifdef GLORB_LOADER_CHECKSUM_EN
      check("start_at_last_we", {31'd0, wr_start[(base + int'(v.nw) - 1) % 128]}, 32'd0);
`else
      check("start_at_last_we", {31'd0, wr_start[(base + int'(v.nw) - 1) % 128]},
            {31'd0, v.exp_start});
`endif
    end
    check("in_ready_terminal", {31'd0, bus8.in_ready}, 32'd0);
    check("busy_terminal",     {31'd0, bus8.busy},     32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, bus8.in_ready}, 32'd0);
    check({tag, "_we"},       {31'd0, bus8.imem_we},  32'd0);
    check({tag, "_addr"},     {28'd0, bus8.imem_addr}, 32'd0);
    check({tag, "_wdata"},    {24'd0, bus8.imem_wdata}, 32'd0);
    check({tag, "_start"},    {31'd0, bus8.start},    32'd0);
    check({tag, "_busy"},     {31'd0, bus8.busy},     32'd0);
    check({tag, "_err"},      {31'd0, bus8.err},      32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 8'h00);
    set_in(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < NV; i++) vecs[i] = '0;
`ifdef GLORB_LOADER_CHECKSUM_EN
    // 03 11 22 33 66 : three words, good checksum
    vecs[0].nb = 5'd5;
    vecs[0].b[0] = 8'h03; vecs[0].b[1] = 8'h11; vecs[0].b[2] = 8'h22;
    vecs[0].b[3] = 8'h33; vecs[0].b[4] = 8'h66;
    vecs[0].nw = 5'd3;
    vecs[0].w[0] = 8'h11; vecs[0].w[1] = 8'h22; vecs[0].w[2] = 8'h33;
    vecs[0].exp_start = 1'b1;
    // 02 AA 55 00 : checksum should be FF
    vecs[1].nb = 5'd4;
    vecs[1].b[0] = 8'h02; vecs[1].b[1] = 8'hAA; vecs[1].b[2] = 8'h55; vecs[1].b[3] = 8'h00;
    vecs[1].nw = 5'd2;
    vecs[1].w[0] = 8'hAA; vecs[1].w[1] = 8'h55;
    vecs[1].exp_err = 1'b1;
    // length 00
    vecs[2].nb = 5'd1; vecs[2].b[0] = 8'h00; vecs[2].exp_err = 1'b1;
    // length 11 (17 > 16)
    vecs[3].nb = 5'd1; vecs[3].b[0] = 8'h11; vecs[3].exp_err = 1'b1;
    // length 10, sixteen 01 bytes, checksum 10
    vecs[4].nb = 5'd18;
    vecs[4].b[0] = 8'h10;
    for (int i = 1; i <= 16; i++) vecs[4].b[i] = 8'h01;
    vecs[4].b[17] = 8'h10;
    vecs[4].nw = 5'd16;
    for (int i = 0; i < 16; i++) vecs[4].w[i] = 8'h01;
    vecs[4].exp_start = 1'b1;
    // 01 07 07
    vecs[5].nb = 5'd3;
    vecs[5].b[0] = 8'h01; vecs[5].b[1] = 8'h07; vecs[5].b[2] = 8'h07;
    vecs[5].nw = 5'd1; vecs[5].w[0] = 8'h07;
    vecs[5].exp_start = 1'b1;
`else
    // 02 12 34 : no checksum byte
    vecs[0].nb = 5'd3;
    vecs[0].b[0] = 8'h02; vecs[0].b[1] = 8'h12; vecs[0].b[2] = 8'h34;
    vecs[0].nw = 5'd2;
    vecs[0].w[0] = 8'h12; vecs[0].w[1] = 8'h34;
    vecs[0].exp_start = 1'b1;
    // 03 11 22 33
    vecs[1].nb = 5'd4;
    vecs[1].b[0] = 8'h03; vecs[1].b[1] = 8'h11; vecs[1].b[2] = 8'h22; vecs[1].b[3] = 8'h33;
    vecs[1].nw = 5'd3;
    vecs[1].w[0] = 8'h11; vecs[1].w[1] = 8'h22; vecs[1].w[2] = 8'h33;
    vecs[1].exp_start = 1'b1;
    // length 00
    vecs[2].nb = 5'd1; vecs[2].b[0] = 8'h00; vecs[2].exp_err = 1'b1;
    // length 11 (17 > 16)
    vecs[3].nb = 5'd1; vecs[3].b[0] = 8'h11; vecs[3].exp_err = 1'b1;
    // length 10, sixteen 01 bytes
    vecs[4].nb = 5'd17;
    vecs[4].b[0] = 8'h10;
    for (int i = 1; i <= 16; i++) vecs[4].b[i] = 8'h01;
    vecs[4].nw = 5'd16;
    for (int i = 0; i < 16; i++) vecs[4].w[i] = 8'h01;
    vecs[4].exp_start = 1'b1;
    // 01 07
    vecs[5].nb = 5'd2;
    vecs[5].b[0] = 8'h01; vecs[5].b[1] = 8'h07;
    vecs[5].nw = 5'd1; vecs[5].w[0] = 8'h07;
    vecs[5].exp_start = 1'b1;
`endif

    // values while reset is held
    #2 rst_n = 1'b0;
    #2 check_reset_outputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_release", {31'd0, bus8.in_ready}, 32'd1);

    // table, back-to-back
    for (int i = 0; i < NV; i++) run_vec(vecs[i], 1'b0, 1'b1);

    // same image with random valid gaps
    run_vec(vecs[0], 1'b1, 1'b1);

    // reset after two data bytes of a 4-word load
    apply_reset();
    send_byte(1'b0, 8'h04, 1'b0);
    send_byte(1'b0, 8'h01, 1'b0);
    send_byte(1'b0, 8'h02, 1'b0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 8'h00);
    check("midload_we",    {31'd0, bus8.imem_we},    32'd1);
    check("midload_addr",  {28'd0, bus8.imem_addr},  32'd1);
    check("midload_wdata", {24'd0, bus8.imem_wdata}, 32'h02);
    check("midload_busy",  {31'd0, bus8.busy},       32'd1);
    rst_n = 1'b0;
    #1 check_reset_outputs("midload_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[5], 1'b0, 1'b0);

    // IW=16: FFFF word; checksum 1FE wraps to FE
    apply_reset();
    begin
      int b16;
      b16 = w16_cnt;
      send_byte(1'b1, 8'h01, 1'b0);
      send_byte(1'b1, 8'hFF, 1'b0);
      send_byte(1'b1, 8'hFF, 1'b0);
`ifdef GLORB_LOADER_CHECKSUM_EN
      send_byte(1'b1, 8'hFE, 1'b0);
`endif
      @(negedge clk);
      set_in(1'b1, 1'b0, 8'h00);
      check("w16_start", {31'd0, bus16.start}, 32'd1);
      check("w16_err",   {31'd0, bus16.err},   32'd0);
      @(negedge clk);
      check("w16_count", w16_cnt - b16, 32'd1);
      check("w16_addr",  {28'd0, w16_addr}, 32'd0);
      check("w16_data",  {16'd0, w16_data}, 32'h0000FFFF);
      check("w16_busy",  {31'd0, bus16.busy}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
